// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the vector reduction sequencer.
package riscv_v_pkg;

  localparam int RISCV_V_NUM_BYTES_DATA = 16;
  localparam int RISCV_V_RED_MAX_STEPS  = $clog2(RISCV_V_NUM_BYTES_DATA);

  // Encoding 3 is reserved and behaves as SUM.
  typedef enum logic [1:0] {
    RED_SUM  = 2'd0,
    RED_MAX  = 2'd1,
    RED_MIN  = 2'd2,
    RED_RSVD = 2'd3
  } riscv_v_red_op_e;

  typedef enum logic [1:0] {
    RED_IDLE = 2'd0,
    RED_RUN  = 2'd1,
    RED_DONE = 2'd2
  } riscv_v_red_state_e;

endpackage

// File: rtl/riscv_v_reduct_pair_sel.sv
// Per-byte-lane merge of one reduction pair: picks the adder result when both
// elements are valid, passes the lone valid element through, else zero.
module riscv_v_reduct_pair_sel #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ev_a,
  input  logic         ev_b,
  input  logic [W-1:0] add_result,
  output logic [W-1:0] acc_nxt,
  output logic         ev_nxt
);

  // Select the surviving value for this lane.
  always_comb begin
    acc_nxt = '0;
    case ({ev_a, ev_b})
      2'b11:   acc_nxt = add_result;
      2'b10:   acc_nxt = a;
      2'b01:   acc_nxt = b;
      default: acc_nxt = '0;
    endcase
  end

  assign ev_nxt = ev_a | ev_b;

endmodule

// File: rtl/riscv_v_reduct_seq.sv
// Multi-cycle vector reduction sequencer. Folds the accumulator in half each
// RUN cycle through an external element-wise adder until one element is left.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. start_ready is high only in IDLE; a request seen while busy is
// dropped, not queued. res_valid stays high with res_data/res_empty stable
// until res_ready is sampled high.
//
// Lane geometry works in bytes: at step k the upper half begins at byte
// DATA_BYTES >> (k+1) regardless of element size, so only the element-valid
// lookup depends on the latched osize.
module riscv_v_reduct_seq
  import riscv_v_pkg::*;
#(
  parameter int DATA_BYTES = RISCV_V_NUM_BYTES_DATA,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [1:0]                     red_op,
  input  logic                           red_signed,
  input  logic [1:0]                     osize,
  input  logic [DATA_BYTES*BYTE_WIDTH-1:0] src_data,
  input  logic [DATA_BYTES-1:0]          src_valid,
  output logic                           add_valid,
  output logic [DATA_BYTES*BYTE_WIDTH-1:0] add_srca,
  output logic [DATA_BYTES*BYTE_WIDTH-1:0] add_srcb,
  output logic [DATA_BYTES-1:0]          add_srcb_valid,
  output logic [3:0]                     add_osize_vector,
  output logic                           add_is_add,
  output logic                           add_is_max,
  output logic                           add_is_min_max,
  output logic                           add_is_arith,
  output logic                           add_is_signed,
  output logic                           add_is_reduct,
  output logic                           add_is_reduct_n,
  input  logic [DATA_BYTES*BYTE_WIDTH-1:0] add_result,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [63:0]                    res_data,
  output logic                           res_empty,
  output logic                           busy,
  output logic [1:0]                     dbg_state_o
);

  localparam int DW      = DATA_BYTES * BYTE_WIDTH;
  localparam int EW      = $clog2(DATA_BYTES);
  localparam int STEP_W  = $clog2(EW + 1);
  localparam int HB_W    = EW + 1;

  riscv_v_red_state_e state_q, state_d;
  riscv_v_red_op_e    op_q, op_d;
  logic [DW-1:0]         acc_q, acc_d;
  logic [DATA_BYTES-1:0] ev_q, ev_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  sgn_q, sgn_d;
  logic [1:0]            osize_q, osize_d;

  logic [HB_W-1:0]       half_b;
  logic [EW-1:0]         elem_mask;
  logic                  last_step;
  logic                  run;
  logic [DW-1:0]         cap_acc, lane_a, lane_b;
  logic [DATA_BYTES-1:0] cap_ev, load_ev, lane_half, lane_low, lane_evn, lane_bv;

  assign half_b    = HB_W'(DATA_BYTES >> (step_q + 1'b1));
  assign elem_mask = EW'((1 << osize_q) - 1);
  assign last_step = (step_q == STEP_W'(EW - 1 - int'(osize_q)));
  assign run       = (state_q == RED_RUN);

  for (genvar j = 0; j < DATA_BYTES; j++) begin : g_lane
    logic [HB_W-1:0]       b_byte;
    logic [EW-1:0]         ea_idx, eb_idx;
    logic [BYTE_WIDTH-1:0] a_byte, b_val, nxt_byte;
    logic                  ev_a, ev_b;

    assign lane_half[j] = (HB_W'(j) < half_b);
    assign lane_low[j]  = ((EW'(j) & elem_mask) == '0);
    assign b_byte       = lane_half[j] ? (HB_W'(j) + half_b) : HB_W'(j);
    assign ea_idx       = EW'(j >> osize_q);
    assign eb_idx       = EW'(b_byte >> osize_q);
    assign a_byte       = acc_q[j*BYTE_WIDTH +: BYTE_WIDTH];
    assign b_val        = BYTE_WIDTH'(acc_q >> (int'(b_byte) * BYTE_WIDTH));
    assign ev_a         = ev_q[ea_idx];
    assign ev_b         = lane_half[j] & ev_q[eb_idx];

    riscv_v_reduct_pair_sel #(.W(BYTE_WIDTH)) u_pair_sel (
      .a          (a_byte),
      .b          (b_val),
      .ev_a       (ev_a),
      .ev_b       (ev_b),
      .add_result (add_result[j*BYTE_WIDTH +: BYTE_WIDTH]),
      .acc_nxt    (nxt_byte),
      .ev_nxt     (lane_evn[j])
    );

    assign lane_a[j*BYTE_WIDTH +: BYTE_WIDTH]  = lane_half[j] ? a_byte : '0;
    assign lane_b[j*BYTE_WIDTH +: BYTE_WIDTH]  = lane_half[j] ? b_val  : '0;
    assign cap_acc[j*BYTE_WIDTH +: BYTE_WIDTH] = lane_half[j] ? nxt_byte : '0;
    assign lane_bv[j] = ev_b;
  end

  // Collapse per-byte valid merges into per-element valid bits (lowest byte owns it).
  always_comb begin
    cap_ev = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (lane_low[j] && lane_half[j]) cap_ev[EW'(j >> osize_q)] = lane_evn[j];
    end
  end

  // Element-valid bits of an incoming vector: an element counts if its lowest byte is valid.
  always_comb begin
    load_ev = '0;
    for (int e = 0; e < DATA_BYTES; e++) begin
      if (e < (DATA_BYTES >> osize)) load_ev[e] = src_valid[EW'(e << osize)];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RED_IDLE;
      op_q    <= RED_SUM;
      acc_q   <= '0;
      ev_q    <= '0;
      step_q  <= '0;
      sgn_q   <= 1'b0;
      osize_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      ev_q    <= ev_d;
      step_q  <= step_d;
      sgn_q   <= sgn_d;
      osize_q <= osize_d;
    end
  end

  // Next-state: load on accept, fold once per RUN cycle, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    ev_d    = ev_q;
    step_d  = step_q;
    sgn_d   = sgn_q;
    osize_d = osize_q;
    case (state_q)
      RED_IDLE: begin
        if (start_valid) begin
          acc_d   = src_data;
          ev_d    = load_ev;
          op_d    = riscv_v_red_op_e'(red_op);
          sgn_d   = red_signed;
          osize_d = osize;
          step_d  = '0;
          state_d = RED_RUN;
        end
      end
      RED_RUN: begin
        acc_d  = cap_acc;
        ev_d   = cap_ev;
        step_d = step_q + 1'b1;
        if (last_step) state_d = RED_DONE;
      end
      RED_DONE: begin
        if (res_ready) state_d = RED_IDLE;
      end
      default: state_d = RED_IDLE;
    endcase
  end

  // Adder drive and result outputs; everything idles at zero outside its state.
  always_comb begin
    add_valid        = run;
    add_srca         = run ? lane_a : '0;
    add_srcb         = run ? lane_b : '0;
    add_srcb_valid   = run ? lane_bv : '0;
    add_osize_vector = run ? (4'b0001 << osize_q) : 4'b0000;
    add_is_add       = run & ((op_q == RED_SUM) | (op_q == RED_RSVD));
    add_is_max       = run & (op_q == RED_MAX);
    add_is_min_max   = run & ((op_q == RED_MAX) | (op_q == RED_MIN));
    add_is_arith     = run;
    add_is_signed    = run & sgn_q;
    add_is_reduct    = 1'b0;
    add_is_reduct_n  = 1'b1;
    res_valid        = (state_q == RED_DONE);
    res_data         = (state_q == RED_DONE) ? acc_q[63:0] : 64'd0;
    res_empty        = (state_q == RED_DONE) & ~ev_q[0];
    start_ready      = (state_q == RED_IDLE);
    busy             = (state_q != RED_IDLE);
    dbg_state_o      = state_q;
  end

endmodule

// File: doc/riscv_v_reduct_seq.md
# riscv_v_reduct_seq

Multi-cycle vector reduction sequencer sitting directly upstream of the vector adder, replacing its single-cycle combinational reduction tree. Accepts one source vector and reduction op (SUM/MAX/MIN). Each cycle it drives the adder with pairwise halves of a registered accumulator and captures the adder result. After log2(N) steps it returns a single scalar element. The adder is driven as an element-wise (non-reduct) unit only.

## Interface
- DATA_BYTES, default RISCV_V_NUM_BYTES_DATA (16): vector width in bytes; power of 2, ≥16.
- BYTE_WIDTH, default 8: bits per byte.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- start_valid  in  1  request present.
- start_ready  out  1  sequencer can accept; high only in IDLE.
- red_op  in  2  riscv_v_red_op_e: SUM=0, MAX=1, MIN=2; 3 is reserved and treated as SUM.
- red_signed  in  1  signed compare for MAX/MIN.
- osize  in  2  log2 element bytes (0=8b … 3=64b).
- src_data  in  DATA_BYTES*8  source vector.
- src_valid  in  DATA_BYTES  per-byte valid; an element is valid iff its lowest byte is valid.
- add_valid  out  1  adder enable (valid_adder); high only in RUN.
- add_srca, add_srcb  out  DATA_BYTES*8  lane operands.
- add_srcb_valid  out  DATA_BYTES  per-byte srcb valid.
- add_osize_vector  out  4  one-hot of osize.
- add_is_add, add_is_max, add_is_min_max, add_is_arith, add_is_signed  out  1  adder op controls.
- add_is_reduct  out  1  tied 0.
- add_is_reduct_n  out  1  tied 1.
- add_result  in  DATA_BYTES*8  adder combinational result.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer accepts.
- res_data  out  64  reduced element, zero-extended.
- res_empty  out  1  no valid element in source; res_data=0.
- busy  out  1  state != IDLE.

## Operation
- N = DATA_BYTES>>osize elements; STEPS = log2(N).
- On accept (start_valid & start_ready):
  - Register src_data into acc.
  - Register element-valid bits into ev[N].
  - Latch op, signed, osize.
  - step=0; state → RUN.
- Each RUN step k, with m = N>>k and h = m/2, for lane i<h:
  - srca = acc[i], srcb = acc[i+h].
  - add_srcb_valid bytes of lane i = ev[i+h].
  - Lanes ≥h are driven 0.
- Capture per lane i<h:
  - Both valid: add_result[i].
  - Only a valid: acc[i].
  - Only b valid: acc[i+h].
  - Neither valid: 0.
  - ev[i] = ev[i] | ev[i+h].
  - Lanes ≥h are cleared.
- SUM wraps modulo element width; adder flags are ignored.
- MAX/MIN use add_is_min_max, with add_is_max=1 for MAX and add_is_max=0 for MIN.
- step==STEPS-1 at capture → DONE.
- DONE:
  - res_data = acc[0]; res_empty = ~ev[0].
  - Hold until res_ready, then → IDLE.
- State machine riscv_v_red_state_e: IDLE → RUN → DONE → IDLE. No other transitions.

## Timing
- Reset values:
  - State IDLE; acc, ev, step cleared.
  - start_ready=1, busy=0, res_valid=0, res_data=0, res_empty=0, add_valid=0.
  - All add_* operands 0.
- Latency: res_valid rises STEPS cycles after the accepting edge.
- Occupancy: STEPS+2 cycles per reduction with res_ready held high.
- start_valid while busy is ignored, not queued; upstream must hold start_valid.
- res_data/res_empty are stable while res_valid & ~res_ready.
- Asynchronous reset mid-RUN or mid-DONE aborts immediately; no res_valid is produced for the aborted request.
- The adder is purely combinational: add_result must be valid in the same cycle its operands are driven.

## Structure
- riscv_v_pkg gets riscv_v_red_op_e, riscv_v_red_state_e and RISCV_V_RED_MAX_STEPS = $clog2(RISCV_V_NUM_BYTES_DATA).
- Sub-module riscv_v_reduct_pair_sel: per-lane valid-merge mux. Inputs: a, b, ev_a, ev_b, add_result. Outputs: next acc lane and next ev.
- Element lanes are generated by osize: byte-lane masks are computed from the latched osize, not from a mux per osize.

## Test plan
- osize=0, SUM, all valid, bytes 1..16 → res_valid after 4 cycles; res_data=0x88 (136 mod 256); res_empty=0.
- osize=1, signed MAX, halfwords {-5,3,0x7FFF,-1,…0}, all valid → res_data=0x7FFF after 3 cycles.
- osize=3, unsigned MIN, elements {0xFFFF_FFFF_FFFF_FFFF, 2} → res_data=2 after 1 cycle.
- osize=0, SUM, src_valid=0x0001, byte0=0x5A, other bytes 0xFF → res_data=0x5A. Then src_valid=0 → res_empty=1, res_data=0.
- res_ready held low 5 cycles in DONE with start_valid high → res_data stable, start_ready=0, no second accept. Release res_ready → IDLE; next request accepted on the following edge.
- rst_n asserted during RUN step 2 → all outputs at reset values immediately. After release, a new SUM request completes correctly.
